// File: rtl/idfi_region_checker_if.sv
// Log-table memory port: checker issues one entry read and holds it until the memory reports done.
// master = checker side, slave = memory side.
interface idfi_region_checker_if #(
  parameter int N_ADDR_WIDTH  = 32,
  parameter int N_ENTRY_WIDTH = 96
);
  logic                     o_rqAccess;
  logic [N_ADDR_WIDTH-1:0]  o_logAddr;
  logic                     i_logDone;
  logic [N_ENTRY_WIDTH-1:0] i_logData;

  modport master (output o_rqAccess, o_logAddr, input i_logDone, i_logData);
  modport slave  (input o_rqAccess, o_logAddr, output i_logDone, i_logData);
endinterface

// File: rtl/idfi_region_checker.sv
// Walks the circular write log and checks each {ID, addr} against a region/allowed-ID table; flags pulse 2 cycles after i_logDone.
// Read request is held until i_logDone, so the memory may stall indefinitely; config writes are never stalled.
module idfi_region_checker #(
  parameter int                    N_ADDR_WIDTH      = 32,
  parameter int                    N_IDLOG_TEMP      = 32,
  parameter int                    N_ADDRLOG_WIDTH   = 32,
  parameter int                    N_DATALOG_WIDTH   = 32,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFF800,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = 32'h1FEFFBF0,
  parameter int                    ENTRY_STRIDE      = 12,
  parameter int                    N_REGIONS         = 4,
  parameter int                    N_IDS             = 32,
  parameter int                    CNT_WIDTH         = 16,
  parameter bit                    STOP_ON_VIOL      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_trigger,
  input  logic [N_ADDR_WIDTH-1:0] i_logAddrptr,
  idfi_region_checker_if.master   logIf,
  input  logic                    i_cfgWe,
  input  logic [3:0]              i_cfgIdx,
  input  logic                    i_cfgEn,
  input  logic [N_ADDR_WIDTH-1:0] i_cfgBase,
  input  logic [N_ADDR_WIDTH-1:0] i_cfgLimit,
  input  logic [N_IDS-1:0]        i_cfgMask,
  output logic                    o_invWrite,
  output logic                    o_invAccess,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_halted,
  output logic [CNT_WIDTH-1:0]    o_violCount
);
  localparam int N_ENTRY  = N_IDLOG_TEMP + N_ADDRLOG_WIDTH + N_DATALOG_WIDTH;
  localparam int ID_IDX_W = (N_IDS > 1) ? $clog2(N_IDS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, CHECK, DONE, HALT} state_t;

  state_t                      state;
  logic [N_ADDR_WIDTH-1:0]     rdPtr;
  logic [N_ADDR_WIDTH-1:0]     endPtr;
  logic                        rqAccess;
  logic [N_IDLOG_TEMP-1:0]     entryId;
  logic [N_ADDRLOG_WIDTH-1:0]  entryAddr;

  logic [N_REGIONS-1:0]        regEn;
  logic [N_ADDR_WIDTH-1:0]     regBase  [N_REGIONS];
  logic [N_ADDR_WIDTH-1:0]     regLimit [N_REGIONS];
  logic [N_IDS-1:0]            regMask  [N_REGIONS];

  logic                        hit;
  logic [N_IDS-1:0]            hitMask;
  logic                        idOk;
  logic                        viol;
  logic [N_ADDR_WIDTH-1:0]     chkAddr;
  logic [N_ADDR_WIDTH-1:0]     nextPtr;
  logic                        unusedData;

  assign logIf.o_rqAccess = rqAccess;
  assign logIf.o_logAddr  = rdPtr;
  assign unusedData       = ^logIf.i_logData[N_DATALOG_WIDTH-1:0];
  assign chkAddr          = N_ADDR_WIDTH'(entryAddr);
  assign nextPtr          = (rdPtr >= LOGTABLE_ADDREND) ? LOGTABLE_ADDRINIT
                                                        : rdPtr + N_ADDR_WIDTH'(ENTRY_STRIDE);

  // Scan from the top down so the lowest-index matching region wins.
  always_comb begin
    hit     = 1'b0;
    hitMask = '0;
    for (int r = N_REGIONS - 1; r >= 0; r--) begin
      if (regEn[r] && (chkAddr >= regBase[r]) && (chkAddr <= regLimit[r])) begin
        hit     = 1'b1;
        hitMask = regMask[r];
      end
    end
  end

  assign idOk = (entryId < N_IDLOG_TEMP'(N_IDS)) && hitMask[entryId[ID_IDX_W-1:0]];
  assign viol = !hit || !idOk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regEn <= '0;
      for (int r = 0; r < N_REGIONS; r++) begin
        regBase[r]  <= '0;
        regLimit[r] <= '0;
        regMask[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < N_REGIONS; r++) begin
        if (i_cfgWe && (i_cfgIdx == 4'(r))) begin
          regEn[r]    <= i_cfgEn;
          regBase[r]  <= i_cfgBase;
          regLimit[r] <= i_cfgLimit;
          regMask[r]  <= i_cfgMask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rdPtr       <= LOGTABLE_ADDRINIT;
      endPtr      <= LOGTABLE_ADDRINIT;
      rqAccess    <= 1'b0;
      entryId     <= '0;
      entryAddr   <= '0;
      o_invWrite  <= 1'b0;
      o_invAccess <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_halted    <= 1'b0;
      o_violCount <= '0;
    end else begin
      o_invWrite  <= 1'b0;
      o_invAccess <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        IDLE, HALT: begin
          // HALT resumes from the already-advanced pointer with a fresh end snapshot.
          if (i_trigger) begin
            endPtr   <= i_logAddrptr;
            o_busy   <= 1'b1;
            o_halted <= 1'b0;
            if (rdPtr == i_logAddrptr) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state    <= REQ;
              rqAccess <= 1'b1;
            end
          end
        end
        REQ: begin
          if (logIf.i_logDone) begin
            entryId   <= logIf.i_logData[N_ENTRY-1 -: N_IDLOG_TEMP];
            entryAddr <= logIf.i_logData[N_ADDRLOG_WIDTH+N_DATALOG_WIDTH-1 -: N_ADDRLOG_WIDTH];
            rqAccess  <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          rdPtr       <= nextPtr;
          o_invAccess <= !hit;
          o_invWrite  <= hit && !idOk;
          if (viol && (o_violCount != '1)) begin
            o_violCount <= o_violCount + CNT_WIDTH'(1);
          end
          if (viol && STOP_ON_VIOL) begin
            state    <= HALT;
            o_halted <= 1'b1;
            o_busy   <= 1'b0;
          end else if (nextPtr == endPtr) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state    <= REQ;
            rqAccess <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_idfi_region_checker.sv
// Directed bench: one free-running walker (dutA) and one stop-on-violation walker (dutB) sharing config and pointer.
module tb_idfi_region_checker;
  logic        clk;
  logic        rst;
  logic        trigA, trigB;
  logic [31:0] ptr;
  logic        doneA, doneB;
  logic [95:0] logData;
  logic        cfgWe;
  logic [3:0]  cfgIdx;
  logic        cfgEn;
  logic [31:0] cfgBase, cfgLimit, cfgMask;

  logic        wA, aA, busyA, doneOutA, haltA;
  logic        wB, aB, busyB, doneOutB, haltB;
  logic [15:0] cntA, cntB;

  bit          useB;
  int          nTests;
  int          nFail;

  logic        curRq, curW, curA, curBusy, curDone, curHalt;
  logic [31:0] curAddr;
  logic [15:0] curCnt;

  idfi_region_checker_if #(.N_ADDR_WIDTH(32), .N_ENTRY_WIDTH(96)) ifA ();
  idfi_region_checker_if #(.N_ADDR_WIDTH(32), .N_ENTRY_WIDTH(96)) ifB ();

  assign ifA.i_logDone = doneA;
  assign ifA.i_logData = logData;
  assign ifB.i_logDone = doneB;
  assign ifB.i_logData = logData;

  idfi_region_checker #(.STOP_ON_VIOL(1'b0)) dutA (
    .clk(clk), .rst(rst), .i_trigger(trigA), .i_logAddrptr(ptr), .logIf(ifA),
    .i_cfgWe(cfgWe), .i_cfgIdx(cfgIdx), .i_cfgEn(cfgEn), .i_cfgBase(cfgBase),
    .i_cfgLimit(cfgLimit), .i_cfgMask(cfgMask),
    .o_invWrite(wA), .o_invAccess(aA), .o_busy(busyA), .o_done(doneOutA),
    .o_halted(haltA), .o_violCount(cntA)
  );

  idfi_region_checker #(.STOP_ON_VIOL(1'b1)) dutB (
    .clk(clk), .rst(rst), .i_trigger(trigB), .i_logAddrptr(ptr), .logIf(ifB),
    .i_cfgWe(cfgWe), .i_cfgIdx(cfgIdx), .i_cfgEn(cfgEn), .i_cfgBase(cfgBase),
    .i_cfgLimit(cfgLimit), .i_cfgMask(cfgMask),
    .o_invWrite(wB), .o_invAccess(aB), .o_busy(busyB), .o_done(doneOutB),
    .o_halted(haltB), .o_violCount(cntB)
  );

  always_comb begin
    curRq   = useB ? ifB.o_rqAccess : ifA.o_rqAccess;
    curAddr = useB ? ifB.o_logAddr  : ifA.o_logAddr;
    curW    = useB ? wB       : wA;
    curA    = useB ? aB       : aA;
    curBusy = useB ? busyB    : busyA;
    curDone = useB ? doneOutB : doneOutA;
    curHalt = useB ? haltB    : haltA;
    curCnt  = useB ? cntB     : cntA;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfgWrite(input logic [3:0] idx, input logic en, input logic [31:0] base,
                          input logic [31:0] limit, input logic [31:0] mask);
    cfgWe = 1'b1; cfgIdx = idx; cfgEn = en; cfgBase = base; cfgLimit = limit; cfgMask = mask;
    @(negedge clk);
    cfgWe = 1'b0;
  endtask

  // Returns in cycle T+1 after the trigger edge.
  task automatic trig();
    if (useB) trigB = 1'b1; else trigA = 1'b1;
    @(negedge clk);
    trigA = 1'b0; trigB = 1'b0;
  endtask

  // Serves one read and returns in cycle D+2, where the flags are checked.
  task automatic fetch(input string tag, input logic [31:0] expAddr, input logic [95:0] ent,
                       input logic expW, input logic expA, input bit cfgInCheck);
    int n;
    n = 0;
    while (!curRq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rq"}, 64'(curRq), 64'd1);
    chk({tag, "_addr"}, 64'(curAddr), 64'(expAddr));
    logData = ent;
    if (useB) doneB = 1'b1; else doneA = 1'b1;
    @(negedge clk);
    doneA = 1'b0; doneB = 1'b0;
    chk({tag, "_rqOffInCheck"}, 64'(curRq), 64'd0);
    if (cfgInCheck) begin
      cfgWe = 1'b1; cfgIdx = 4'd1; cfgEn = 1'b0;
    end
    @(negedge clk);
    cfgWe = 1'b0;
    chk({tag, "_invWrite"}, 64'(curW), 64'(expW));
    chk({tag, "_invAccess"}, 64'(curA), 64'(expA));
  endtask

  initial begin
    nTests = 0; nFail = 0; useB = 1'b0;
    rst = 1'b0; trigA = 1'b0; trigB = 1'b0; ptr = 32'h1FEFF800;
    doneA = 1'b0; doneB = 1'b0; logData = '0;
    cfgWe = 1'b0; cfgIdx = '0; cfgEn = 1'b0; cfgBase = '0; cfgLimit = '0; cfgMask = '0;

    repeat (3) @(negedge clk);
    chk("rst_rq", 64'(curRq), 64'd0);
    chk("rst_addr", 64'(curAddr), 64'h1FEFF800);
    chk("rst_busy", 64'(curBusy), 64'd0);
    chk("rst_done", 64'(curDone), 64'd0);
    chk("rst_halt", 64'(curHalt), 64'd0);
    chk("rst_cnt", 64'(curCnt), 64'd0);
    chk("rst_flags", 64'({curW, curA}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    cfgWrite(4'd0, 1'b1, 32'h0, 32'hFF, 32'h4);

    // Allowed writer in region0.
    ptr = 32'h1FEFF80C;
    trig();
    chk("t1_busy", 64'(curBusy), 64'd1);
    fetch("t1", 32'h1FEFF800, 96'h000000020000001400000020, 1'b0, 1'b0, 1'b0);
    chk("t1_done", 64'(curDone), 64'd1);
    chk("t1_cnt", 64'(curCnt), 64'd0);
    @(negedge clk);
    chk("t1_busyOff", 64'(curBusy), 64'd0);
    chk("t1_doneOff", 64'(curDone), 64'd0);
    chk("t1_nextAddr", 64'(curAddr), 64'h1FEFF80C);

    // Disallowed writer ID 7.
    ptr = 32'h1FEFF818;
    trig();
    fetch("t2", 32'h1FEFF80C, {32'd7, 32'h14, 32'h90}, 1'b1, 1'b0, 1'b0);
    chk("t2_cnt", 64'(curCnt), 64'd1);
    chk("t2_done", 64'(curDone), 64'd1);
    @(negedge clk);
    chk("t2_pulseEnd", 64'(curW), 64'd0);

    // Address outside every region.
    ptr = 32'h1FEFF824;
    trig();
    fetch("t3", 32'h1FEFF818, {32'd2, 32'h1000, 32'h0}, 1'b0, 1'b1, 1'b0);
    chk("t3_cnt", 64'(curCnt), 64'd2);
    @(negedge clk);

    cfgWrite(4'd1, 1'b1, 32'h1000, 32'h1FFF, 32'h4);
    ptr = 32'h1FEFF830;
    trig();
    fetch("t4", 32'h1FEFF824, {32'd2, 32'h1000, 32'h0}, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt", 64'(curCnt), 64'd2);
    @(negedge clk);

    // Region1 disabled during the first CHECK: applies only to the second entry.
    ptr = 32'h1FEFF848;
    trig();
    fetch("t5a", 32'h1FEFF830, {32'd2, 32'h1000, 32'h0}, 1'b0, 1'b0, 1'b1);
    fetch("t5b", 32'h1FEFF83C, {32'd2, 32'h1000, 32'h0}, 1'b0, 1'b1, 1'b0);
    chk("t5_cnt", 64'(curCnt), 64'd3);
    chk("t5_done", 64'(curDone), 64'd1);
    @(negedge clk);

    // Walk up to the last table entry.
    ptr = 32'h1FEFFBF0;
    trig();
    for (int i = 0; i < 78; i++) begin
      fetch("t6", 32'h1FEFF848 + 32'(12 * i), {32'd2, 32'h14, 32'h0}, 1'b0, 1'b0, 1'b0);
    end
    chk("t6_done", 64'(curDone), 64'd1);
    @(negedge clk);

    // Wrap from the last entry back to the first.
    ptr = 32'h1FEFF80C;
    trig();
    fetch("t7a", 32'h1FEFFBF0, {32'd2, 32'h14, 32'h0}, 1'b0, 1'b0, 1'b0);
    fetch("t7b", 32'h1FEFF800, {32'd2, 32'h14, 32'h0}, 1'b0, 1'b0, 1'b0);
    chk("t7_done", 64'(curDone), 64'd1);
    chk("t7_cnt", 64'(curCnt), 64'd3);
    @(negedge clk);
    chk("t7_addr", 64'(curAddr), 64'h1FEFF80C);

    // Empty walk: rdptr already equals the producer pointer.
    trig();
    chk("t8_done", 64'(curDone), 64'd1);
    chk("t8_rq", 64'(curRq), 64'd0);
    chk("t8_busy", 64'(curBusy), 64'd1);
    @(negedge clk);
    chk("t8_busyOff", 64'(curBusy), 64'd0);
    chk("t8_rqOff", 64'(curRq), 64'd0);

    // Reset mid-request.
    ptr = 32'h1FEFF818;
    trig();
    chk("t9_rqBefore", 64'(curRq), 64'd1);
    rst = 1'b0;
    #1;
    chk("t9_rq", 64'(curRq), 64'd0);
    chk("t9_busy", 64'(curBusy), 64'd0);
    chk("t9_addr", 64'(curAddr), 64'h1FEFF800);
    chk("t9_cnt", 64'(curCnt), 64'd0);
    chk("t9_done", 64'(curDone), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ptr = 32'h1FEFF80C;
    trig();
    fetch("t9_noRegion", 32'h1FEFF800, {32'd2, 32'h14, 32'h0}, 1'b0, 1'b1, 1'b0);
    chk("t9_cntAfter", 64'(curCnt), 64'd1);
    @(negedge clk);

    // Stop-on-violation walker.
    useB = 1'b1;
    cfgWrite(4'd0, 1'b1, 32'h0, 32'hFF, 32'h4);
    ptr = 32'h1FEFF824;
    trig();
    fetch("b1", 32'h1FEFF800, {32'd2, 32'h14, 32'h0}, 1'b0, 1'b0, 1'b0);
    fetch("b2", 32'h1FEFF80C, {32'd7, 32'h14, 32'h0}, 1'b1, 1'b0, 1'b0);
    chk("b2_halted", 64'(curHalt), 64'd1);
    chk("b2_busy", 64'(curBusy), 64'd0);
    chk("b2_done", 64'(curDone), 64'd0);
    chk("b2_cnt", 64'(curCnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2_noReq", 64'(curRq), 64'd0);
    end
    trig();
    chk("b3_haltClr", 64'(curHalt), 64'd0);
    chk("b3_busy", 64'(curBusy), 64'd1);
    fetch("b3", 32'h1FEFF818, {32'd2, 32'h14, 32'h0}, 1'b0, 1'b0, 1'b0);
    chk("b3_done", 64'(curDone), 64'd1);
    @(negedge clk);
    chk("b3_busyOff", 64'(curBusy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/idfi_region_checker.md
# idfi_region_checker

Parametrised successor to the iDFI checker. It walks the circular write-log table in memory from its own read pointer up to the producer's pointer, fetching one 96-bit log entry per request/done handshake. Each entry (writer ID, write address, data) is checked against a runtime-programmable table of N_REGIONS address regions, each carrying an allowed-writer ID mask. The block sits between the log-table memory port and the hypervisor violation/interrupt logic.

## Interface
- N_ADDR_WIDTH, 32, address width of log table and checked addresses
- N_IDLOG_TEMP, 32, ID field width in a log entry
- N_ADDRLOG_WIDTH, 32, address field width
- N_DATALOG_WIDTH, 32, data field width
- LOGTABLE_ADDRINIT, 32'h1FEFF800, first entry address
- LOGTABLE_ADDREND, 32'h1FEFFBF0, last entry address (inclusive)
- ENTRY_STRIDE, 12, bytes per entry
- N_REGIONS, 4, region table depth (1..16)
- N_IDS, 32, allowed-ID mask width
- CNT_WIDTH, 16, violation counter width
- STOP_ON_VIOL, 0, 1 = halt walk on first violation
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_trigger  in  1  start walk (pulse)
- i_logAddrptr  in  N_ADDR_WIDTH  producer write pointer (next free entry)
- o_rqAccess  out  1  read request to log memory
- o_logAddr  out  N_ADDR_WIDTH  address of requested entry
- i_logDone  in  1  read complete, i_logData valid this cycle
- i_logData  in  N_IDLOG_TEMP+N_ADDRLOG_WIDTH+N_DATALOG_WIDTH  {ID, addr, data}, ID in MSBs
- i_cfgWe  in  1  region table write strobe
- i_cfgIdx  in  4  region index
- i_cfgEn  in  1  region enable
- i_cfgBase, i_cfgLimit  in  N_ADDR_WIDTH each  inclusive bounds
- i_cfgMask  in  N_IDS  allowed writer IDs
- o_invWrite  out  1  pulse: writer ID not allowed in matched region
- o_invAccess  out  1  pulse: address matches no enabled region
- o_busy  out  1  walk in progress
- o_done  out  1  pulse: walk finished
- o_halted  out  1  walk stopped on violation
- o_violCount  out  CNT_WIDTH  saturating violation count

## Operation
- States: IDLE, REQ, CHECK, DONE, HALT.
- IDLE: on i_trigger, snapshot i_logAddrptr as end pointer. If rdptr == snapshot, go to DONE; otherwise go to REQ.
- REQ: o_rqAccess=1, o_logAddr=rdptr, held until i_logDone. On i_logDone, capture i_logData and go to CHECK.
- CHECK: the lowest-index enabled region with base<=addr<=limit matches.
  - No match: o_invAccess; o_invWrite stays 0.
  - Match with ID>=N_IDS or mask[ID]==0: o_invWrite.
  - rdptr advances by ENTRY_STRIDE; after LOGTABLE_ADDREND it wraps to LOGTABLE_ADDRINIT.
  - On violation with STOP_ON_VIOL=1: go to HALT. Else if new rdptr == snapshot: go to DONE. Else: go to REQ.
- DONE: o_done for 1 cycle, then IDLE.
- HALT: o_halted=1. i_trigger re-snapshots the end pointer and resumes from the already-advanced rdptr.
- i_trigger is ignored in REQ, CHECK and DONE.
- Config writes are accepted in any state. A write coinciding with CHECK takes effect from the next entry. After reset all regions are disabled.
- o_violCount increments once per violating entry and saturates at all-ones.

## Timing
- Reset (rst=0, async): state IDLE, rdptr=LOGTABLE_ADDRINIT, all outputs 0 (o_logAddr=LOGTABLE_ADDRINIT), region table disabled.
- i_trigger high at edge T: o_busy=1 and o_rqAccess=1 from cycle T+1.
- i_logDone high in cycle D: o_rqAccess=0 in D+1 (CHECK), and flags pulse high for exactly cycle D+2.
  - The next request asserts in D+2, so minimum throughput is 1 entry per 2 cycles plus memory latency.
- o_done is high one cycle after the final CHECK. o_busy is low from the cycle after o_done.
- i_logDone outside REQ is ignored.
- Reset mid-walk aborts immediately, and no flag or done pulse is produced.

## Test plan
- Region0 = [0x0,0xFF], mask 0x4, enabled. rdptr 0x1FEFF800, ptr 0x1FEFF80C, trigger, entry 96'h000000020000001400000020 -> no flags, o_done, o_logAddr next 0x1FEFF80C, count 0.
- Same region, entry ID 7 addr 0x14 data 0x90 -> o_invWrite 1 cycle at D+2, o_invAccess 0, count 1.
- Entry ID 2 addr 0x1000 -> o_invAccess only, count +1. Repeat with region1 = [0x1000,0x1FFF] mask 0x4 -> no flags.
- Wrap: rdptr 0x1FEFFBF0, ptr 0x1FEFF80C -> requests at 0x1FEFFBF0, 0x1FEFF800, then o_done. Trigger with rdptr == ptr -> o_done, no request.
- STOP_ON_VIOL=1, three entries with a bad second entry -> o_halted after the second entry and no third request. A retrigger fetches the third entry, then o_done.
- rst low while o_rqAccess=1 -> all outputs 0 at once, o_logAddr=0x1FEFF800, count 0. Config write during CHECK does not affect the current entry.
